// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: register addressing and scoreboard counter width.
// Also used by the scoreboard built with or without WB_BYPASS_EN.
package mips_pkg;
    localparam int          REG_ADDR_W = 5;
    localparam int          NUM_REGS   = 32;
    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam int          CNT_W      = 2;
endpackage

// File: rtl/scoreboard_cell.sv
// One per-register pending-write counter with a sticky underflow flag.
module scoreboard_cell
    import mips_pkg::*;
#(
    parameter int CNT_W = mips_pkg::CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             i_inc,
    input  logic             i_wb,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_err
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_dec;

    // A writeback only retires a pending write; against a zero count it is an error.
    assign w_dec = i_wb && (r_cnt != '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_inc && !w_dec) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!i_inc && w_dec) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (i_wb && (r_cnt == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_err = r_err;

endmodule

// File: rtl/dest_scoreboard.sv
// Destination-register scoreboard: per-register pending counters and decode RAW stall.
// Optional macro WB_BYPASS_EN lets a same-cycle writeback clear a last-pending hazard.
module dest_scoreboard
    import mips_pkg::*;
#(
    parameter int CNT_W = mips_pkg::CNT_W
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  IssueValid,
    input  logic                  IssueRegWrite,
    input  logic [REG_ADDR_W-1:0] IssueDest,
    input  logic [REG_ADDR_W-1:0] RsAddr,
    input  logic [REG_ADDR_W-1:0] RtAddr,
    input  logic                  WbValid,
    input  logic [REG_ADDR_W-1:0] WbDest,
    output logic                  Stall,
    output logic                  IssueAccept,
    output logic [NUM_REGS-1:0]   PendingVec,
    output logic                  Err
);

    // Handshake: decode offers with IssueValid; the instruction is taken in a cycle
    // exactly when IssueAccept (IssueValid && !Stall) is high, and Stall is never
    // raised without IssueValid.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_err;
    logic [CNT_W-1:0]    w_rs_cnt, w_rt_cnt, w_dst_cnt;
    logic                w_rs_byp, w_rt_byp, w_dst_byp;
    logic                w_rs_haz, w_rt_haz, w_ovf_haz;

    // Register 0 is hardwired and never tracked.
    assign w_cnt[0] = '0;
    assign w_err[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
        logic w_inc;
        logic w_wb;
        assign w_inc = IssueAccept && IssueRegWrite && (IssueDest == REG_ADDR_W'(g));
        assign w_wb  = WbValid && (WbDest == REG_ADDR_W'(g));
        scoreboard_cell #(.CNT_W(CNT_W)) u_cell (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .i_inc (w_inc),
            .i_wb  (w_wb),
            .o_cnt (w_cnt[g]),
            .o_err (w_err[g])
        );
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
        assign PendingVec[g] = |w_cnt[g];
    end

    assign w_rs_cnt  = w_cnt[RsAddr];
    assign w_rt_cnt  = w_cnt[RtAddr];
    assign w_dst_cnt = w_cnt[IssueDest];

`ifdef WB_BYPASS_EN
    // Write-first register file: the retiring value is readable this same cycle.
    assign w_rs_byp  = WbValid && (WbDest == RsAddr) && (w_rs_cnt == CNT_W'(1));
    assign w_rt_byp  = WbValid && (WbDest == RtAddr) && (w_rt_cnt == CNT_W'(1));
    assign w_dst_byp = WbValid && (WbDest == IssueDest);
`else
    assign w_rs_byp  = 1'b0;
    assign w_rt_byp  = 1'b0;
    assign w_dst_byp = 1'b0;
`endif

    assign w_rs_haz  = (w_rs_cnt != '0) && !w_rs_byp;
    assign w_rt_haz  = (w_rt_cnt != '0) && !w_rt_byp;
    assign w_ovf_haz = IssueRegWrite && (IssueDest != REG_ZERO) &&
                       (w_dst_cnt == CNT_MAX) && !w_dst_byp;

    assign Stall       = IssueValid && (w_rs_haz || w_rt_haz || w_ovf_haz);
    assign IssueAccept = IssueValid && !Stall;
    assign Err         = |w_err;

endmodule

// File: tb/tb_dest_scoreboard.sv
// Directed bench for dest_scoreboard; expectations follow WB_BYPASS_EN when defined.
module tb_dest_scoreboard;
    import mips_pkg::*;

    logic        Clk, Rst_n;
    logic        IssueValid, IssueRegWrite, WbValid;
    logic [4:0]  IssueDest, RsAddr, RtAddr, WbDest;
    logic        Stall, IssueAccept, Err;
    logic [31:0] PendingVec;

    int total = 0;
    int bad   = 0;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    dest_scoreboard u_dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .IssueValid    (IssueValid),
        .IssueRegWrite (IssueRegWrite),
        .IssueDest     (IssueDest),
        .RsAddr        (RsAddr),
        .RtAddr        (RtAddr),
        .WbValid       (WbValid),
        .WbDest        (WbDest),
        .Stall         (Stall),
        .IssueAccept   (IssueAccept),
        .PendingVec    (PendingVec),
        .Err           (Err)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // driver tasks
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] dst,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic wv, input logic [4:0] wd);
        IssueValid    = v;
        IssueRegWrite = rw;
        IssueDest     = dst;
        RsAddr        = rs;
        RtAddr        = rt;
        WbValid       = wv;
        WbDest        = wd;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_pending", PendingVec, 32'h0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_accept", {31'd0, IssueAccept}, 32'd0);
        chk("rst_err", {31'd0, Err}, 32'd0);
        Rst_n = 1'b1;
        tick();

        // RAW on Rs after issue to r8, cleared by writeback
        drive(1, 1, 5'd8, 5'd1, 5'd2, 0, 0);
        chk("i8_accept", {31'd0, IssueAccept}, 32'd1);
        tick();
        drive(1, 0, 5'd0, 5'd8, 5'd2, 0, 0);
        chk("i8_pending", PendingVec, 32'h0000_0100);
        chk("rs8_stall", {31'd0, Stall}, 32'd1);
        chk("rs8_accept", {31'd0, IssueAccept}, 32'd0);
        tick();
        drive(1, 0, 5'd0, 5'd8, 5'd2, 1, 5'd8);
        chk("rs8_wb_stall", {31'd0, Stall}, {31'd0, !BYP});
        tick();
        drive(1, 0, 5'd0, 5'd8, 5'd2, 0, 0);
        chk("rs8_after_wb_stall", {31'd0, Stall}, 32'd0);
        chk("rs8_after_wb_pend", PendingVec, 32'h0);
        tick();

        // RAW on Rt
        drive(1, 1, 5'd9, 5'd0, 5'd0, 0, 0);
        tick();
        drive(1, 0, 5'd0, 5'd0, 5'd9, 0, 0);
        chk("rt9_stall", {31'd0, Stall}, 32'd1);
        drive(0, 0, 5'd0, 5'd0, 5'd9, 0, 0);
        chk("rt9_novalid_stall", {31'd0, Stall}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 5'd9);
        tick();

        // overflow guard on r5
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'd5, 5'd0, 5'd0, 0, 0);
            chk("r5_fill_accept", {31'd0, IssueAccept}, 32'd1);
            tick();
        end
        drive(1, 1, 5'd5, 5'd0, 5'd0, 0, 0);
        chk("r5_ovf_stall", {31'd0, Stall}, 32'd1);
        chk("r5_ovf_accept", {31'd0, IssueAccept}, 32'd0);
        chk("r5_ovf_pending", PendingVec, 32'h0000_0020);
        tick();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd5);
        tick();
        drive(1, 1, 5'd5, 5'd0, 5'd0, 0, 0);
        chk("r5_after_wb_accept", {31'd0, IssueAccept}, 32'd1);
        tick();
        drive(1, 1, 5'd5, 5'd0, 5'd0, 0, 0);
        chk("r5_full_again", {31'd0, Stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd5);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r5_drained", PendingVec, 32'h0);
        chk("r5_no_err", {31'd0, Err}, 32'd0);

        // same-cycle issue and writeback on r12
        drive(1, 1, 5'd12, 5'd0, 5'd0, 0, 0);
        tick();
        drive(1, 1, 5'd12, 5'd0, 5'd0, 1, 5'd12);
        chk("r12_both_accept", {31'd0, IssueAccept}, 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r12_still_pending", PendingVec, 32'h0000_1000);
        drive(0, 0, 0, 0, 0, 1, 5'd12);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r12_cleared", PendingVec, 32'h0);

        // register 0 is never tracked
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 5'd0, 5'd0, 5'd0, 1, 5'd0);
            chk("r0_stall", {31'd0, Stall}, 32'd0);
            chk("r0_accept", {31'd0, IssueAccept}, 32'd1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r0_pending", PendingVec, 32'h0);
        chk("r0_no_err", {31'd0, Err}, 32'd0);

        // underflow on r20 sets sticky Err
        drive(0, 0, 0, 0, 0, 1, 5'd20);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("r20_err", {31'd0, Err}, 32'd1);
        chk("r20_pending", PendingVec, 32'h0);
        tick();
        tick();
        chk("r20_err_sticky", {31'd0, Err}, 32'd1);

        // asynchronous reset mid-operation
        drive(1, 1, 5'd3, 5'd0, 5'd0, 0, 0);
        tick();
        drive(1, 1, 5'd4, 5'd0, 5'd0, 0, 0);
        tick();
        drive(1, 0, 5'd0, 5'd3, 5'd4, 0, 0);
        chk("pre_rst_pending", PendingVec, 32'h0000_0018);
        chk("pre_rst_stall", {31'd0, Stall}, 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_rst_pending", PendingVec, 32'h0);
        chk("async_rst_stall", {31'd0, Stall}, 32'd0);
        chk("async_rst_err", {31'd0, Err}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        Rst_n = 1'b1;
        tick();
        chk("post_rst_pending", PendingVec, 32'h0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
